// File: rtl/uart_rx_oversample.sv
// 16x-oversampling UART receiver: synchronised input, start-bit validation, 3-sample majority vote.
// Optional even-parity frames (start, 8 data, parity, stop) when UART_RX_PARITY_EN is defined.
module uart_rx_oversample #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       sysclk,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_err
`endif
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, rx_s_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [3:0]       tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             s7_q, s7_d, s8_q, s8_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q, busy_d;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
`endif

  logic tick, vote, at_vote, at_end;

  always_comb begin
    tick    = (div_q == DIV_LAST);
    vote    = (s7_q & s8_q) | (s7_q & rx_s_q) | (s8_q & rx_s_q);
    at_vote = tick && (tick_q == 4'd9);
    at_end  = tick && (tick_q == 4'd15);

    state_d     = state_q;
    div_d       = div_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    s7_d        = s7_q;
    s8_d        = s8_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif

    if (state_q != IDLE) begin
      if (tick) begin
        div_d  = '0;
        tick_d = tick_q + 4'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
      if (tick && tick_q == 4'd7) s7_d = rx_s_q;
      if (tick && tick_q == 4'd8) s8_d = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        // Restart the bit timebase on the detected falling edge.
        if (!rx_s_q) begin
          state_d = START;
          div_d   = '0;
          tick_d  = 4'd0;
          bit_d   = 3'd0;
        end
      end
      START: begin
        if (at_vote && vote) state_d = IDLE;
        else if (at_end)     state_d = DATA;
      end
      DATA: begin
        if (at_vote) shift_d = {vote, shift_q[7:1]};
        if (at_end) begin
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (at_vote) par_bad_d = vote ^ (^shift_q);
        if (at_end)  state_d = STOP;
      end
`endif
      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is not missed.
        if (at_vote) begin
          if (vote) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            parity_err_d = par_bad_q;
`endif
            state_d = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      rx_s_q      <= 1'b1;
      div_q       <= '0;
      tick_q      <= 4'd0;
      bit_q       <= 3'd0;
      shift_q     <= 8'h00;
      s7_q        <= 1'b0;
      s8_q        <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= rx_in;
      rx_s_q      <= sync1_q;
      div_q       <= div_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      s7_q        <= s7_d;
      s8_q        <= s8_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Testbench for uart_rx_oversample: line-level frame model with queued expected bytes.
// Build with +define+UART_RX_PARITY_EN to exercise the parity variant.
module tb_uart_rx_oversample;

  localparam int CLK_HZ  = 1_600_000;
  localparam int BAUD    = 10_000;
  localparam int DIV     = CLK_HZ / (BAUD * 16);
  localparam int BIT_CYC = DIV * 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME_CYC = NBITS * BIT_CYC;

  logic       sysclk = 1'b0;
  logic       reset  = 1'b0;
  logic       rx_in  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx_oversample #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(16)) dut (
    .sysclk    (sysclk),
    .reset     (reset),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #5 sysclk = ~sysclk;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned start_cyc = 0;
  logic [7:0]  last_good = 8'h00;

  logic [7:0]  got_q[$];
  int unsigned got_cyc[$];
  logic        perr_q[$];
  int          ferr_cnt = 0;
  logic        prev_v = 1'b0, prev_f = 1'b0;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Pulse monitor: capture every rx_valid byte and frame_err; pulses must be single and exclusive.
  always @(negedge sysclk) begin
    if (reset) begin
      if (rx_valid) begin
        got_q.push_back(rx_data);
        got_cyc.push_back(cyc);
`ifdef UART_RX_PARITY_EN
        perr_q.push_back(parity_err);
`endif
      end
      if (frame_err) ferr_cnt = ferr_cnt + 1;
      if (rx_valid || frame_err) begin
        checks = checks + 1;
        if ((rx_valid && frame_err) || (rx_valid && prev_v) || (frame_err && prev_f)) begin
          errors = errors + 1;
          $display("FAIL pulse_shape: valid=%0b ferr=%0b prev_valid=%0b prev_ferr=%0b required single exclusive pulses",
                   rx_valid, frame_err, prev_v, prev_f);
        end
      end
    end
    prev_v <= rx_valid;
    prev_f <= frame_err;
  end

  // Line value of frame bit idx for byte d (start, LSB-first data, [parity], stop).
  function automatic logic frame_bit(input logic [7:0] d, input int idx, input logic stop_bit,
                                     input logic par_flip);
    logic [7:0] dv;
    dv = d;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return dv[idx-1];
    if (idx == NBITS - 1) return stop_bit;
    return (^dv) ^ par_flip;
  endfunction

  // Pin-cycle index whose value the receiver sees at sample tick t of frame bit b.
  function automatic int sample_idx(input int b, input int t);
    return (16 * b + t + 1) * DIV - 1;
  endfunction

  task automatic drive_cycles(input logic [7:0] d, input logic stop_bit, input int noise_at,
                              input logic par_flip, input int ncyc);
    logic v;
    start_cyc = cyc;
    for (int c = 0; c < ncyc; c++) begin
      v = frame_bit(d, c / BIT_CYC, stop_bit, par_flip);
      if (c == noise_at) v = ~v;
      rx_in = v;
      @(negedge sysclk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int noise_at,
                            input logic par_flip);
    drive_cycles(d, stop_bit, noise_at, par_flip, FRAME_CYC);
  endtask

  task automatic idle(input int n);
    rx_in = 1'b1;
    repeat (n) @(negedge sysclk);
  endtask

  task automatic clear_mon();
    got_q.delete();
    got_cyc.delete();
    perr_q.delete();
    ferr_cnt = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rx_in = 1'b0;
    repeat (5) @(negedge sysclk);
    checks = checks + 1;
    if ({rx_data, rx_valid, frame_err, busy} !== 11'h0) begin
      errors = errors + 1;
      $display("FAIL reset_outputs: data=%02h valid=%0b ferr=%0b busy=%0b required all zero",
               rx_data, rx_valid, frame_err, busy);
    end
    rx_in = 1'b1;
    repeat (3) @(negedge sysclk);
    reset = 1'b1;
    idle(10);
    checks = checks + 1;
    if (busy !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_idle_busy: got %0b required 0", busy);
    end
  endtask

  task automatic test_single();
    int lat;
    clear_mon();
    send_frame(8'hA5, 1'b1, -1, 1'b0);
    idle(200);
    last_good = 8'hA5;
    checks = checks + 1;
    if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
      errors = errors + 1;
      $display("FAIL single_data: got %0d bytes first=%02h required 1 byte a5", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    // Stop-bit decision at tick 9 of the last bit plus 3 cycles of sync/edge detect.
    lat = (got_cyc.size() > 0) ? int'(got_cyc[0] - start_cyc) : -1;
    checks = checks + 1;
    if (lat < (NBITS - 1) * BIT_CYC + 10 * DIV || lat > (NBITS - 1) * BIT_CYC + 10 * DIV + 6) begin
      errors = errors + 1;
      $display("FAIL single_latency: got %0d cycles required about %0d", lat,
               (NBITS - 1) * BIT_CYC + 10 * DIV + 3);
    end
    checks = checks + 1;
    if (busy !== 1'b0 || ferr_cnt != 0) begin
      errors = errors + 1;
      $display("FAIL single_idle: busy=%0b ferr=%0d required 0/0", busy, ferr_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    clear_mon();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    for (int i = 0; i < 6; i++) exp_q.push_back(8'($urandom_range(0, 255)));
    foreach (exp_q[i]) send_frame(exp_q[i], 1'b1, -1, 1'b0);
    idle(300);
    checks = checks + 1;
    if (got_q.size() != exp_q.size()) begin
      errors = errors + 1;
      $display("FAIL b2b_count: got %0d bytes required %0d", got_q.size(), exp_q.size());
    end
    foreach (exp_q[i]) begin
      b = (i < got_q.size()) ? got_q[i] : 8'hxx;
      checks = checks + 1;
      if (b !== exp_q[i]) begin
        errors = errors + 1;
        $display("FAIL b2b_data[%0d]: got %02h required %02h", i, b, exp_q[i]);
      end
    end
    last_good = exp_q[exp_q.size() - 1];
  endtask

  task automatic test_glitch();
    clear_mon();
    rx_in = 1'b0;
    repeat (20) @(negedge sysclk);
    checks = checks + 1;
    if (busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL glitch_busy_during: got %0b required 1", busy);
    end
    repeat (20) @(negedge sysclk);
    idle(200);
    checks = checks + 1;
    if (busy !== 1'b0 || got_q.size() != 0 || ferr_cnt != 0 || rx_data !== last_good) begin
      errors = errors + 1;
      $display("FAIL glitch_rejected: busy=%0b bytes=%0d ferr=%0d data=%02h required 0/0/0/%02h",
               busy, got_q.size(), ferr_cnt, rx_data, last_good);
    end
  endtask

  task automatic test_framing();
    clear_mon();
    send_frame(8'h3C, 1'b0, -1, 1'b0);
    repeat (5 * BIT_CYC) @(negedge sysclk);
    checks = checks + 1;
    if (ferr_cnt != 1 || got_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL framing_pulse: ferr=%0d bytes=%0d required 1/0", ferr_cnt, got_q.size());
    end
    checks = checks + 1;
    if (rx_data !== last_good || busy !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL framing_hold: data=%02h busy=%0b required %02h/1", rx_data, busy, last_good);
    end
    idle(10);
    checks = checks + 1;
    if (busy !== 1'b0 || ferr_cnt != 1) begin
      errors = errors + 1;
      $display("FAIL framing_release: busy=%0b ferr=%0d required 0/1", busy, ferr_cnt);
    end
  endtask

  task automatic test_noise();
    int ticks[8] = '{1, 3, 5, 7, 8, 9, 12, 14};
    logic [7:0] d;
    int bpos, t;
    clear_mon();
    send_frame(8'h55, 1'b1, sample_idx(3, 8), 1'b0);
    idle(50);
    checks = checks + 1;
    if (got_q.size() != 1 || got_q[0] !== 8'h55) begin
      errors = errors + 1;
      $display("FAIL noise_55: got %0d bytes first=%02h required 1 byte 55", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    for (int i = 0; i < 8; i++) begin
      clear_mon();
      d    = 8'($urandom_range(0, 255));
      bpos = $urandom_range(1, 8);
      t    = ticks[$urandom_range(0, 7)];
      send_frame(d, 1'b1, sample_idx(bpos, t), 1'b0);
      idle(50);
      checks = checks + 1;
      if (got_q.size() != 1 || got_q[0] !== d || ferr_cnt != 0) begin
        errors = errors + 1;
        $display("FAIL noise_rand bit=%0d tick=%0d: got %0d bytes first=%02h ferr=%0d required %02h",
                 bpos, t, got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx, ferr_cnt, d);
      end
      last_good = d;
    end
  endtask

  task automatic test_reset_mid_frame();
    clear_mon();
    drive_cycles(8'h81, 1'b1, -1, 1'b0, 4 * BIT_CYC + 37);
    reset = 1'b0;
    repeat (3) @(negedge sysclk);
    checks = checks + 1;
    if ({rx_data, rx_valid, frame_err, busy} !== 11'h0) begin
      errors = errors + 1;
      $display("FAIL reset_mid_outputs: data=%02h valid=%0b ferr=%0b busy=%0b required all zero",
               rx_data, rx_valid, frame_err, busy);
    end
    rx_in = 1'b1;
    @(negedge sysclk);
    reset = 1'b1;
    idle(FRAME_CYC);
    last_good = 8'h00;
    checks = checks + 1;
    if (got_q.size() != 0 || ferr_cnt != 0 || rx_data !== 8'h00) begin
      errors = errors + 1;
      $display("FAIL reset_mid_no_pulse: bytes=%0d ferr=%0d data=%02h required 0/0/00",
               got_q.size(), ferr_cnt, rx_data);
    end
    send_frame(8'h81, 1'b1, -1, 1'b0);
    idle(50);
    checks = checks + 1;
    if (got_q.size() != 1 || got_q[0] !== 8'h81) begin
      errors = errors + 1;
      $display("FAIL reset_mid_recover: got %0d bytes first=%02h required 1 byte 81", got_q.size(),
               got_q.size() > 0 ? got_q[0] : 8'hxx);
    end
    last_good = 8'h81;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] d;
    clear_mon();
    send_frame(8'h07, 1'b1, -1, 1'b1);
    idle(50);
    checks = checks + 1;
    if (got_q.size() != 1 || got_q[0] !== 8'h07 || perr_q.size() != 1 || perr_q[0] !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL parity_bad: bytes=%0d data=%02h perr=%0b required 07 with parity_err 1",
               got_q.size(), got_q.size() > 0 ? got_q[0] : 8'hxx,
               perr_q.size() > 0 ? perr_q[0] : 1'bx);
    end
    for (int i = 0; i < 4; i++) begin
      clear_mon();
      d = 8'($urandom_range(0, 255));
      send_frame(d, 1'b1, -1, 1'(i & 1));
      idle(50);
      checks = checks + 1;
      if (got_q.size() != 1 || got_q[0] !== d || perr_q.size() != 1 || perr_q[0] !== 1'(i & 1)) begin
        errors = errors + 1;
        $display("FAIL parity_rand[%0d]: data=%02h perr=%0b required %02h/%0b", i,
                 got_q.size() > 0 ? got_q[0] : 8'hxx, perr_q.size() > 0 ? perr_q[0] : 1'bx,
                 d, 1'(i & 1));
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_noise();
    test_reset_mid_frame();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
